// File: rtl/lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
//   MA-stage load-result unit. Follows each LSU data-phase transfer on the AHB
//   bus, captures the read word when hready completes the phase, optionally
//   spends one CHECK cycle consuming the LSU EDAC verdict (substituting the
//   corrected word on a correctable error), then aligns and sign/zero-extends
//   the loaded value for write-back. Bus errors and a data-phase watchdog
//   timeout are reported as single-cycle pulses.
//
// Parameters
//   EDAC     1: CHECK cycle present, einfo honoured; 0: result straight after capture
//   TMO_W    width of the wait-state counter
//   TMO_CYC  hready-low cycles within one data phase that raise a timeout
//
// Ports
//   s_clk_i, s_resetn_i            clock, async active-low reset
//   s_flush_i                      cancel any pending result
//   s_dp_valid_i                   first cycle of a data phase
//   s_dp_funct_i[3:0]              [3]=write [2]=unsigned [1:0]=size (B/H/W)
//   s_dp_addr_i[1:0]               byte offset of the request
//   s_hready_i, s_hresp_i          AHB completion / error response
//   s_hrdata_i[31:0]               AHB read word
//   s_fixed_data_i, s_einfo_i      EDAC corrected word and {uce,ce,error}
//   s_stall_o                      hold the MA stage
//   s_result_valid_o, s_result_o   aligned load result, one-cycle pulse
//   s_ce_o, s_uce_o                EDAC status alongside the result
//   s_berr_o, s_timeout_o          bus error / watchdog pulses
// ----------------------------------------------------------------------------
module lsu_load_align #(
    parameter int EDAC    = 1,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_flush_i,
    input  logic        s_dp_valid_i,
    input  logic [3:0]  s_dp_funct_i,
    input  logic [1:0]  s_dp_addr_i,
    input  logic        s_hready_i,
    input  logic        s_hresp_i,
    input  logic [31:0] s_hrdata_i,
    input  logic [31:0] s_fixed_data_i,
    input  logic [2:0]  s_einfo_i,
    output logic        s_stall_o,
    output logic        s_result_valid_o,
    output logic [31:0] s_result_o,
    output logic        s_ce_o,
    output logic        s_uce_o,
    output logic        s_berr_o,
    output logic        s_timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

    state_t            state_q;
    logic [TMO_W-1:0]  cnt_q;
    logic [TMO_W-1:0]  cnt_inc;
    logic [31:0]       word_q;
    logic [3:0]        funct_q;
    logic [1:0]        addr_q;
    logic              drop_q;
    logic              rv_q;
    logic [31:0]       res_q;
    logic              ce_q;
    logic              uce_q;
    logic              berr_q;
    logic              tmo_q;

    // Byte/half extraction plus extension. size=11 falls through to word.
    function automatic logic [31:0] align_word(input logic [31:0] w,
                                               input logic [3:0]  f,
                                               input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f[1:0])
            2'b00:   align_word = f[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   align_word = f[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: align_word = w;
        endcase
    endfunction

    // Saturating increment so a huge TMO_CYC can never wrap the counter.
    assign cnt_inc = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + TMO_W'(1);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            funct_q <= '0;
            addr_q  <= '0;
            drop_q  <= 1'b0;
            rv_q    <= 1'b0;
            res_q   <= '0;
            ce_q    <= 1'b0;
            uce_q   <= 1'b0;
            berr_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            // All status outputs are single-cycle pulses.
            rv_q   <= 1'b0;
            ce_q   <= 1'b0;
            uce_q  <= 1'b0;
            berr_q <= 1'b0;
            tmo_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // Flush wins over a new transfer presented the same cycle.
                    if (s_flush_i) begin
                        state_q <= IDLE;
                    end else if (s_dp_valid_i) begin
                        funct_q <= s_dp_funct_i;
                        addr_q  <= s_dp_addr_i;
                        if (s_hready_i) begin
                            word_q <= s_hrdata_i;
                            if (s_dp_funct_i[3]) begin
                                state_q <= IDLE;
                            end else if (EDAC != 0) begin
                                state_q <= CHECK;
                            end else begin
                                state_q <= DONE;
                                rv_q    <= 1'b1;
                                res_q   <= align_word(s_hrdata_i, s_dp_funct_i, s_dp_addr_i);
                            end
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= TMO_W'(1);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end

                WAIT: begin
                    // hready=1 with hresp=1 is the second cycle of an AHB
                    // error, so completion is checked first.
                    if (s_hready_i) begin
                        word_q <= s_hrdata_i;
                        cnt_q  <= '0;
                        drop_q <= 1'b0;
                        if (funct_q[3] || drop_q || s_flush_i) begin
                            state_q <= IDLE;
                        end else if (EDAC != 0) begin
                            state_q <= CHECK;
                        end else begin
                            state_q <= DONE;
                            rv_q    <= 1'b1;
                            res_q   <= align_word(s_hrdata_i, funct_q, addr_q);
                        end
                    end else if (s_hresp_i) begin
                        berr_q  <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        drop_q  <= 1'b0;
                    end else if (cnt_inc >= TMO_LIM) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        drop_q  <= 1'b0;
                    end else begin
                        // A flush here only marks the result for discard;
                        // the bus phase itself must still be seen through.
                        cnt_q <= cnt_inc;
                        if (s_flush_i) drop_q <= 1'b1;
                    end
                end

                CHECK: begin
                    if (s_flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                        rv_q    <= 1'b1;
                        // Uncorrectable outranks correctable: a word flagged
                        // both ways cannot be trusted as "fixed".
                        if (s_einfo_i[0] && s_einfo_i[2]) begin
                            res_q <= align_word(word_q, funct_q, addr_q);
                            uce_q <= 1'b1;
                        end else if (s_einfo_i[0] && s_einfo_i[1]) begin
                            res_q <= align_word(s_fixed_data_i, funct_q, addr_q);
                            ce_q  <= 1'b1;
                        end else begin
                            res_q <= align_word(word_q, funct_q, addr_q);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // A flush landing on the DONE cycle kills the already-registered pulse.
    assign s_result_valid_o = rv_q  & ~s_flush_i;
    assign s_ce_o           = ce_q  & ~s_flush_i;
    assign s_uce_o          = uce_q & ~s_flush_i;
    assign s_result_o       = res_q;
    assign s_berr_o         = berr_q;
    assign s_timeout_o      = tmo_q;

    assign s_stall_o = (state_q == WAIT) || (state_q == CHECK) ||
                       (((state_q == IDLE) || (state_q == DONE)) &&
                        s_dp_valid_i && !s_hready_i);

endmodule

// File: tb/tb_lsu_load_align.sv
// ----------------------------------------------------------------------------
// tb_lsu_load_align
//   Directed bench for lsu_load_align (EDAC=1, TMO_CYC=4). Expected load
//   results are queued when the completing transfer is driven and popped by a
//   monitor whenever the DUT raises s_result_valid_o; control outputs (stall,
//   berr, timeout, valid timing) are checked inline at fixed cycles.
// ----------------------------------------------------------------------------
module tb_lsu_load_align;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        dp_valid;
    logic [3:0]  funct;
    logic [1:0]  addr;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] fixed;
    logic [2:0]  einfo;
    logic        stall;
    logic        rv;
    logic [31:0] result;
    logic        ce;
    logic        uce;
    logic        berr;
    logic        tmo;

    typedef struct packed {
        logic [31:0] res;
        logic        ce;
        logic        uce;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n;

    lsu_load_align #(.EDAC(1), .TMO_W(8), .TMO_CYC(4)) dut (
        .s_clk_i          (clk),
        .s_resetn_i       (resetn),
        .s_flush_i        (flush),
        .s_dp_valid_i     (dp_valid),
        .s_dp_funct_i     (funct),
        .s_dp_addr_i      (addr),
        .s_hready_i       (hready),
        .s_hresp_i        (hresp),
        .s_hrdata_i       (hrdata),
        .s_fixed_data_i   (fixed),
        .s_einfo_i        (einfo),
        .s_stall_o        (stall),
        .s_result_valid_o (rv),
        .s_result_o       (result),
        .s_ce_o           (ce),
        .s_uce_o          (uce),
        .s_berr_o         (berr),
        .s_timeout_o      (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_in();
        flush    = 1'b0;
        dp_valid = 1'b0;
        funct    = 4'd0;
        addr     = 2'd0;
        hready   = 1'b1;
        hresp    = 1'b0;
        hrdata   = 32'd0;
        fixed    = 32'd0;
        einfo    = 3'd0;
    endtask

    task automatic dp(input logic [3:0] f, input logic [1:0] a,
                      input logic rdy, input logic [31:0] d);
        idle_in();
        dp_valid = 1'b1;
        funct    = f;
        addr     = a;
        hready   = rdy;
        hrdata   = d;
    endtask

    // Zero-wait load, clean EDAC verdict, result must appear two cycles later.
    task automatic zload(input string tag, input logic [3:0] f, input logic [1:0] a,
                         input logic [31:0] d, input logic [31:0] e);
        dp(f, a, 1'b1, d);
        sb.push_back('{res: e, ce: 1'b0, uce: 1'b0});
        nxt();
        idle_in();
        hrdata = ~d;
        nxt();
        sample();
        chk({tag, "_valid"}, {31'd0, rv}, 32'd1);
        nxt();
    endtask

    // Scoreboard consumer: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && rv) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_result: observed %h expected no result", result);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_ce", {31'd0, ce}, {31'd0, e.ce});
                chk("sb_uce", {31'd0, uce}, {31'd0, e.uce});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        sample();
        chk("rst_valid",  {31'd0, rv},    32'd0);
        chk("rst_result", result,         32'd0);
        chk("rst_ce_uce", {30'd0, ce, uce}, 32'd0);
        chk("rst_berr",   {31'd0, berr},  32'd0);
        chk("rst_tmo",    {31'd0, tmo},   32'd0);
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        nxt();

        // LB signed, addr 3, zero wait: latency T+2, one-cycle pulse.
        dp(4'b0000, 2'd3, 1'b1, 32'h80FF_1234);
        sb.push_back('{res: 32'hFFFF_FF80, ce: 1'b0, uce: 1'b0});
        sample();
        chk("lb_stall_t0", {31'd0, stall}, 32'd0);
        nxt();
        idle_in();
        hrdata = 32'hDEAD_BEEF;
        sample();
        chk("lb_stall_check", {31'd0, stall}, 32'd1);
        chk("lb_valid_t1",    {31'd0, rv},    32'd0);
        nxt();
        sample();
        chk("lb_valid_t2", {31'd0, rv}, 32'd1);
        nxt();
        sample();
        chk("lb_valid_t3", {31'd0, rv}, 32'd0);
        nxt();

        // LHU addr 2 with three wait states.
        n = 0;
        dp(4'b0101, 2'd2, 1'b0, 32'd0);
        sample(); n += int'(stall); nxt();
        idle_in(); hready = 1'b0;
        repeat (2) begin sample(); n += int'(stall); nxt(); end
        idle_in(); hrdata = 32'hBEEF_0000;
        sb.push_back('{res: 32'h0000_BEEF, ce: 1'b0, uce: 1'b0});
        sample(); n += int'(stall); nxt();
        chk("lhu_stall_cycles", n, 32'd4);
        idle_in();
        sample();
        chk("lhu_stall_check", {31'd0, stall}, 32'd1);
        nxt();
        sample();
        chk("lhu_valid", {31'd0, rv},    32'd1);
        chk("lhu_stall_done", {31'd0, stall}, 32'd0);
        nxt();

        // LW with correctable error: fixed data substituted.
        dp(4'b0010, 2'd0, 1'b1, 32'h1234_5679);
        sb.push_back('{res: 32'h1234_5678, ce: 1'b1, uce: 1'b0});
        nxt();
        idle_in(); einfo = 3'b011; fixed = 32'h1234_5678;
        nxt();
        sample();
        chk("lw_ce_valid", {31'd0, rv}, 32'd1);
        nxt();

        // LW with uncorrectable error: raw word, uce flagged.
        dp(4'b0010, 2'd0, 1'b1, 32'hCAFE_F00D);
        sb.push_back('{res: 32'hCAFE_F00D, ce: 1'b0, uce: 1'b1});
        nxt();
        idle_in(); einfo = 3'b101; fixed = 32'h0000_0000;
        nxt();
        nxt();

        // Bus error after two hready-low cycles.
        dp(4'b0010, 2'd0, 1'b0, 32'd0);
        nxt();
        idle_in(); hready = 1'b0;
        nxt();
        hresp = 1'b1;
        sample();
        chk("berr_early", {31'd0, berr}, 32'd0);
        nxt();
        idle_in(); hresp = 1'b1;
        sample();
        chk("berr_pulse", {31'd0, berr},  32'd1);
        chk("berr_stall", {31'd0, stall}, 32'd0);
        chk("berr_no_result", {31'd0, rv}, 32'd0);
        nxt();
        idle_in();
        sample();
        chk("berr_one_cycle", {31'd0, berr}, 32'd0);
        nxt();

        // Watchdog: four hready-low cycles with TMO_CYC=4.
        dp(4'b0010, 2'd0, 1'b0, 32'd0);
        nxt();
        idle_in(); hready = 1'b0;
        nxt();
        nxt();
        sample();
        chk("tmo_early", {31'd0, tmo},   32'd0);
        chk("tmo_stall_wait", {31'd0, stall}, 32'd1);
        nxt();
        sample();
        chk("tmo_pulse", {31'd0, tmo},   32'd1);
        chk("tmo_stall_drop", {31'd0, stall}, 32'd0);
        nxt();
        idle_in();
        sample();
        chk("tmo_one_cycle", {31'd0, tmo}, 32'd0);
        nxt();

        // Flush in WAIT, completion discarded, then back-to-back loads.
        dp(4'b0010, 2'd0, 1'b0, 32'd0);
        nxt();
        idle_in(); hready = 1'b0; flush = 1'b1;
        sample();
        chk("drop_stall_wait", {31'd0, stall}, 32'd1);
        nxt();
        idle_in(); hrdata = 32'h5555_5555;
        sample();
        chk("drop_stall_cmpl", {31'd0, stall}, 32'd1);
        nxt();
        dp(4'b0100, 2'd1, 1'b1, 32'h0000_AB00);
        sb.push_back('{res: 32'h0000_00AB, ce: 1'b0, uce: 1'b0});
        sample();
        chk("drop_no_valid", {31'd0, rv}, 32'd0);
        nxt();
        idle_in();
        nxt();
        dp(4'b0001, 2'd2, 1'b1, 32'h8001_0000);
        sb.push_back('{res: 32'hFFFF_8001, ce: 1'b0, uce: 1'b0});
        sample();
        chk("b2b_a_valid", {31'd0, rv}, 32'd1);
        nxt();
        idle_in();
        sample();
        chk("b2b_gap", {31'd0, rv}, 32'd0);
        nxt();
        sample();
        chk("b2b_b_valid", {31'd0, rv}, 32'd1);
        nxt();

        // A waited load after the drop must deliver again.
        dp(4'b0010, 2'd0, 1'b0, 32'd0);
        nxt();
        idle_in(); hrdata = 32'h0BAD_F00D;
        sb.push_back('{res: 32'h0BAD_F00D, ce: 1'b0, uce: 1'b0});
        nxt();
        idle_in();
        nxt();
        sample();
        chk("post_drop_valid", {31'd0, rv}, 32'd1);
        nxt();

        // Flush during CHECK: no result.
        dp(4'b0010, 2'd0, 1'b1, 32'h1111_1111);
        nxt();
        idle_in(); flush = 1'b1;
        nxt();
        idle_in();
        sample();
        chk("flush_check_none", {31'd0, rv}, 32'd0);
        nxt();

        // Flush on the DONE cycle suppresses the pulse.
        dp(4'b0010, 2'd0, 1'b1, 32'h2222_2222);
        nxt();
        idle_in(); einfo = 3'b011;
        nxt();
        idle_in(); flush = 1'b1;
        sample();
        chk("flush_done_valid", {31'd0, rv}, 32'd0);
        chk("flush_done_ce",    {31'd0, ce}, 32'd0);
        nxt();

        // Flush beats a simultaneous dp_valid.
        dp(4'b0010, 2'd0, 1'b1, 32'h3333_3333);
        flush = 1'b1;
        nxt();
        idle_in();
        sample();
        chk("flush_prio_stall", {31'd0, stall}, 32'd0);
        nxt();
        sample();
        chk("flush_prio_none", {31'd0, rv}, 32'd0);
        nxt();

        // Alignment / extension table.
        zload("lh_addr1",  4'b0001, 2'd1, 32'h1234_F00F, 32'hFFFF_F00F);
        zload("lb_pos",    4'b0000, 2'd2, 32'h007F_0000, 32'h0000_007F);
        zload("lbu_a0",    4'b0100, 2'd0, 32'h0000_00FE, 32'h0000_00FE);
        zload("lh_hi_pos", 4'b0001, 2'd3, 32'h7FFF_8000, 32'h0000_7FFF);
        zload("size11",    4'b0011, 2'd2, 32'h89AB_CDEF, 32'h89AB_CDEF);

        // Stores never produce a result.
        dp(4'b1010, 2'd0, 1'b1, 32'h4444_4444);
        sample();
        chk("st_stall0", {31'd0, stall}, 32'd0);
        nxt();
        idle_in();
        sample();
        chk("st_stall1", {31'd0, stall}, 32'd0);
        nxt();
        dp(4'b1010, 2'd0, 1'b0, 32'd0);
        sample();
        chk("stw_stall0", {31'd0, stall}, 32'd1);
        nxt();
        idle_in();
        sample();
        chk("stw_stall1", {31'd0, stall}, 32'd1);
        nxt();
        sample();
        chk("stw_stall2", {31'd0, stall}, 32'd0);
        nxt();

        repeat (3) nxt();
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
